scan_test_controller: RTL



---
 rtl/scan_test_pkg.sv | 31 +++
 rtl/scan_test_lfsr.sv | 30 +++
 rtl/scan_test_controller.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/scan_test_pkg.sv
`default_nettype none
// ============================================================================
// Package     : scan_test_pkg
// Description : Shared types and constants for the scan test controller:
//               FSM state encoding, default chain length, and the LFSR seed,
//               taps and step function used by the optional pattern generator.
// Revision    : 1.0 - initial release
// ============================================================================
package scan_test_pkg;

  localparam int CHAIN_LEN_DEFAULT = 8;

  // Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1. The register shifts left and
  // the feedback enters at bit 0, so the taps sit at bit indices 7,5,4,3.
  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_UNLOAD  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_test_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : scan_test_lfsr
// Description : 8-bit Fibonacci LFSR pattern source, advanced one step per
//               cycle while step is high. Reset loads LFSR_SEED.
// Ports       : clk   - clock
//               rst_n - synchronous active-low reset
//               step  - advance the sequence by one state
//               q     - current LFSR state
// Revision    : 1.0 - initial release
// ============================================================================
module scan_test_lfsr
  import scan_test_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= LFSR_SEED;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule
`default_nettype wire

// File: rtl/scan_test_controller.sv
`default_nettype none
// ============================================================================
// Module      : scan_test_controller
// Description : Tester-side driver for the scan chain around the multiplier
//               core. Per test: shift the stimulus in LSB first, pulse one
//               capture cycle, shift the product out, and compare it with a
//               locally computed golden product.
// Build macro : SCAN_TEST_LFSR_EN - stimulus comes from an internal LFSR
//               (pattern ignored) and a saturating fail counter is added.
// Ports       : clk      - clock
//               rst_n    - synchronous active-low reset
//               start    - request one test (sampled only when idle)
//               pattern  - stimulus, [HALF-1:0]=operand A, upper half=B
//               chain_so - chain serial output
//               scan_en  - chain shift enable (1=shift, 0=capture)
//               scan_in  - chain serial input
//               busy     - test in progress
//               done     - one-cycle pulse, response/pass valid
//               pass     - response matched golden product
//               response - unloaded product
//               fail_cnt - (LFSR build only) saturating failed-test count
// Revision    : 1.0 - initial release
// ============================================================================
module scan_test_controller
  import scan_test_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEFAULT,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic                 chain_so,
  output logic                 scan_en,
  output logic                 scan_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] response
`ifdef SCAN_TEST_LFSR_EN
  ,
  output logic [7:0]           fail_cnt
`endif
);

  localparam int               HALF = CHAIN_LEN / 2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  state_t               state;
  state_t               state_nx;
  logic [CNT_W-1:0]     counter;
  logic                 last_bit;
  logic [CHAIN_LEN-1:0] stim;
  logic [CHAIN_LEN-1:0] pat_q;
  logic [CHAIN_LEN-1:0] expected;
  logic [CHAIN_LEN-1:0] golden;
  logic                 load_bit;
  // Unload shifter keeps only the upper CHAIN_LEN-1 bits: the bit that would
  // land in position 0 is only ever needed on the final edge, where it is
  // taken straight from resp_nx into response.
  logic [CHAIN_LEN-2:0] resp;
  logic [CHAIN_LEN-1:0] resp_nx;

  // --------------------------------------------------------------------------
  // Stimulus source
  // --------------------------------------------------------------------------
`ifdef SCAN_TEST_LFSR_EN
  logic [7:0] lfsr_q;
  logic       unused_pattern;

  scan_test_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (state == ST_DONE),
    .q     (lfsr_q)
  );

  assign stim           = CHAIN_LEN'(lfsr_q);
  assign unused_pattern = ^pattern;
`else
  assign stim = pattern;
`endif

  assign golden = {{HALF{1'b0}}, stim[HALF-1:0]} *
                  {{HALF{1'b0}}, stim[CHAIN_LEN-1:HALF]};

  assign last_bit = (counter == LAST);
  assign resp_nx  = {chain_so, resp};
  // Select pat_q[counter] without an oversized index expression.
  assign load_bit = |(pat_q & ({{(CHAIN_LEN-1){1'b0}}, 1'b1} << counter));

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Scan pins are decoded only from registered state, counter and pat_q.
  always_comb begin
    state_nx = state;
    scan_en  = 1'b0;
    scan_in  = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        scan_en = 1'b1;
        scan_in = load_bit;
        if (last_bit) state_nx = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_nx = ST_UNLOAD;
      end
      ST_UNLOAD: begin
        scan_en = 1'b1;
        if (last_bit) state_nx = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: counter, stimulus latch, unload shifter and comparator
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      counter  <= '0;
      pat_q    <= '0;
      expected <= '0;
      resp     <= '0;
      response <= '0;
      pass     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          counter <= '0;
          if (start) begin
            pat_q    <= stim;
            expected <= golden;
            response <= '0;
            pass     <= 1'b0;
          end
        end
        ST_LOAD: begin
          counter <= last_bit ? '0 : counter + CNT_W'(1);
        end
        ST_CAPTURE: begin
          counter <= '0;
        end
        ST_UNLOAD: begin
          counter <= last_bit ? '0 : counter + CNT_W'(1);
          resp    <= resp_nx[CHAIN_LEN-1:1];
          // Publish on the final unload edge so the result is already valid
          // during the DONE cycle.
          if (last_bit) begin
            response <= resp_nx;
            pass     <= (resp_nx == expected);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SCAN_TEST_LFSR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fail_cnt <= 8'h00;
    end else if (state == ST_DONE && !pass && fail_cnt != 8'hFF) begin
      fail_cnt <= fail_cnt + 8'h01;
    end
  end
`endif

endmodule
`default_nettype wire
